function_unit_seq: RTL and testbench

Registered, parametrised function unit for the RISC datapath: the next-generation replacement for the combinational function unit. Computes the same FS-coded arithmetic/logic/shift operations at any width, adds arithmetic shift right and a multi-cycle shift-add multiply, and registers the result and flags behind a valid/ready handshake. It sits between the register-file read stage and the write-back stage, so the control unit can stall on multiply.

---
 rtl/function_unit_seq.sv | 129 ++++++++++++
 tb/tb_function_unit_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/function_unit_seq.sv
// function_unit_seq: registered FS-coded ALU/shifter with valid/ready handshake and optional multiply
//   Optional feature macro: FU_MUL_EN (FS=01100 runs a WIDTH-cycle shift-add multiply).
//   Ports: clk, reset (sync, active-high); request in_valid/in_ready with A, B, FS, SH;
//   response out_valid/out_ready with result F and flags C (carry), V (overflow), Z (zero), N (negative).
module function_unit_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FS,
  input  logic [SHW-1:0]   SH,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             C,
  output logic             V,
  output logic             Z,
  output logic             N
);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH:0] a_x, b_x, nb_x, r;
  logic [WIDTH-1:0] sra, f_n, f_q, f_d;
  logic v, c_n, v_n, accept, load;
  logic c_q, c_d, v_q, v_d, ov_q, ov_d;
  assign a_x = {1'b0, A};
  assign b_x = {1'b0, B};
  assign nb_x = {1'b0, ~B};
  assign sra = $signed(A) >>> SH;
  // {carry, result} of every single-cycle op, plus signed overflow
  always_comb begin
    r = '0;
    v = 1'b0;
    case (FS)
      5'b00000, 5'b00111: r = a_x;
      5'b00001: begin r = a_x + ONE; v = A == MAXP; end
      5'b00010: begin r = a_x + b_x; v = A[WIDTH-1] == B[WIDTH-1] && r[WIDTH-1] != A[WIDTH-1]; end
      5'b00011: r = a_x + b_x + ONE;
      5'b00100: r = a_x + nb_x;
      5'b00101: begin r = {A < B, A - B}; v = A[WIDTH-1] != B[WIDTH-1] && r[WIDTH-1] != A[WIDTH-1]; end
      5'b00110: begin r = {A == '0, A - ONE[WIDTH-1:0]}; v = A == MINN; end
      5'b01000: r = {1'b0, A & B};
      5'b01001: r = {1'b0, A | B};
      5'b01010: r = {1'b0, A ^ B};
      5'b01011: r = {1'b0, ~A};
      5'b11100: r = b_x;
      5'b11101: r = {1'b0, A << SH};
      5'b11110: r = {1'b0, A >> SH};
      5'b11111: r = {1'b0, sra};
      default: r = '0;
    endcase
  end
`ifdef FU_MUL_EN
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL = 1'b1;
  logic [0:0] st_q, st_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0] psum;
  logic mul_go, mul_done;
  assign in_ready = st_q == IDLE && (!ov_q || out_ready);
  assign accept = in_valid && in_ready;
  assign mul_go = accept && FS == 5'b01100;
  assign mul_done = st_q == MUL && cnt_q == SHW'(WIDTH - 1);
  // p_q holds {partial product, remaining multiplier bits}; one bit retired per cycle
  assign psum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mc_q} : '0);
  always_comb begin
    st_d = mul_go ? MUL : mul_done ? IDLE : st_q;
    cnt_d = st_q == MUL ? cnt_q + SHW'(1) : '0;
    mc_d = mul_go ? A : mc_q;
    p_d = mul_go ? {{WIDTH{1'b0}}, B} : st_q == MUL ? {psum, p_q[WIDTH-1:1]} : p_q;
  end
  assign load = (accept && !mul_go) || mul_done;
  assign f_n = mul_done ? p_d[WIDTH-1:0] : r[WIDTH-1:0];
  assign c_n = mul_done ? |p_d[2*WIDTH-1:WIDTH] : r[WIDTH];
  assign v_n = mul_done ? 1'b0 : v;
  always_ff @(posedge clk)
    if (reset) begin
      st_q <= IDLE;
      cnt_q <= '0;
      mc_q <= '0;
      p_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      mc_q <= mc_d;
      p_q <= p_d;
    end
`else
  assign in_ready = !ov_q || out_ready;
  assign accept = in_valid && in_ready;
  assign load = accept;
  assign f_n = r[WIDTH-1:0];
  assign c_n = r[WIDTH];
  assign v_n = v;
`endif
  // a result loaded on the same edge it is consumed keeps out_valid high
  always_comb begin
    f_d = load ? f_n : f_q;
    c_d = load ? c_n : c_q;
    v_d = load ? v_n : v_q;
    ov_d = load || (ov_q && !out_ready);
  end
  always_ff @(posedge clk)
    if (reset) begin
      f_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      f_q <= f_d;
      c_q <= c_d;
      v_q <= v_d;
      ov_q <= ov_d;
    end
  assign F = f_q;
  assign C = c_q;
  assign V = v_q;
  assign Z = f_q == '0;
  assign N = f_q[WIDTH-1];
  assign out_valid = ov_q;
endmodule

// File: tb/tb_function_unit_seq.sv
// tb_function_unit_seq: randomized self-checking bench for function_unit_seq against a behavioural model
module tb_function_unit_seq;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, C, V, Z, N;
  logic [W-1:0] A, B, F;
  logic [4:0] FS, SH;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  function_unit_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .FS(FS), .SH(SH),
    .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .C(C), .V(V), .Z(Z), .N(N)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // returns {F, C, V} from signed/unsigned integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [4:0] fs, input logic [4:0] sh);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned res = 0;
    longint unsigned prod;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s = 0;
    logic c = 1'b0;
    logic v;
    prod = ua * ub;
    case (fs)
      5'd0, 5'd7: res = ua;
      5'd1: begin res = ua + 1; s = sa + 1; end
      5'd2: begin res = ua + ub; s = sa + sb; end
      5'd3: res = ua + ub + 1;
      5'd4: res = ua + (64'hFFFF_FFFF - ub);
      5'd5: begin res = (ua - ub) & 64'hFFFF_FFFF; c = ua < ub; s = sa - sb; end
      5'd6: begin res = (ua - 1) & 64'hFFFF_FFFF; c = ua == 0; s = sa - 1; end
      5'd8: res = ua & ub;
      5'd9: res = ua | ub;
      5'd10: res = ua ^ ub;
      5'd11: res = 64'hFFFF_FFFF - ua;
      5'd28: res = ub;
      5'd29: res = (ua << sh) & 64'hFFFF_FFFF;
      5'd30: res = ua >> sh;
      5'd31: res = 64'(sa >>> sh) & 64'hFFFF_FFFF;
`ifdef FU_MUL_EN
      5'd12: begin res = prod & 64'hFFFF_FFFF; c = (prod >> 32) != 0; end
`endif
      default: res = 0;
    endcase
    if (fs inside {5'd1, 5'd2, 5'd3, 5'd4}) c = res[32];
    v = s > 64'sd2147483647 || s < -64'sd2147483648;
    return {res[W-1:0], c, v};
  endfunction
  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0; B = '0; FS = '0; SH = '0;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (F !== '0) begin fails++; $display("FAIL reset_F got %h exp 0", F); end
    tests++; if (Z !== 1'b1) begin fails++; $display("FAIL reset_Z got %b exp 1", Z); end
    tests++; if (N !== 1'b0) begin fails++; $display("FAIL reset_N got %b exp 0", N); end
    tests++; if (C !== 1'b0) begin fails++; $display("FAIL reset_C got %b exp 0", C); end
    tests++; if (V !== 1'b0) begin fails++; $display("FAIL reset_V got %b exp 0", V); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_directed();
    logic [W-1:0] ta [11] = '{32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                              32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000};
    logic [W-1:0] tb_ [11] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h1};
    logic [4:0] tf [11] = '{5'b00010, 5'b00101, 5'b11110, 5'b11111, 5'b11101, 5'b00001, 5'b00110,
                            5'b00110, 5'b00010, 5'b11110, 5'b00101};
    logic [4:0] ts [11] = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [W-1:0] ef [11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0800_0000, 32'hF800_0000, 32'h0,
                              32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 32'h7FFF_FFFF};
    logic [1:0] ecv [11] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [W+4:0] got, exp;
    for (int i = 0; i < 11; i++) begin
      A = ta[i]; B = tb_[i]; FS = tf[i]; SH = ts[i];
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      got = {out_valid, F, C, V, Z, N};
      exp = {1'b1, ef[i], ecv[i], ef[i] == '0, ef[i][W-1]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL directed_%0d got v=%b F=%h C=%b V=%b Z=%b N=%b exp %h", i, out_valid, F, C, V, Z, N, exp);
      end
    end
    cyc();
  endtask
  task automatic test_random();
    logic [W+1:0] m;
    logic [W+4:0] got, exp;
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 4) != 0);
      A = $urandom();
      B = $urandom();
      if ($urandom_range(0, 3) == 0) A = (A[0]) ? 32'h7FFF_FFFF : 32'h8000_0000;
      FS = 5'($urandom_range(0, 31));
`ifdef FU_MUL_EN
      if (FS == 5'b01100) FS = 5'b00010;
`endif
      SH = 5'($urandom_range(0, 31));
      m = model(A, B, FS, SH);
      cyc();
      got = {out_valid, F, C, V, Z, N};
      exp = in_valid ? {1'b1, m, m[W+1:2] == '0, m[W+1]} : {1'b0, got[W+3:0]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL random_%0d fs=%b got v=%b F=%h C=%b V=%b Z=%b N=%b exp %h", i, FS, out_valid, F, C, V, Z, N, exp);
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask
  task automatic test_backpressure();
    A = 32'd5; B = 32'd3; FS = 5'b01000; SH = '0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    cyc();
    A = 32'hFFFF; FS = 5'b01001;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({out_valid, in_ready, F} !== {2'b10, 32'd1}) begin
        fails++;
        $display("FAIL backpressure_hold_%0d got v=%b rdy=%b F=%h exp v=1 rdy=0 F=1", i, out_valid, in_ready, F);
      end
      cyc();
    end
    A = 32'd5; B = 32'd3; FS = 5'b01001;
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL backpressure_ready got %b exp 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, F} !== {1'b1, 32'd7}) begin
      fails++;
      $display("FAIL back_to_back got v=%b F=%h exp v=1 F=7", out_valid, F);
    end
    cyc();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL consume_clear got %b exp 0", out_valid); end
  endtask
`ifdef FU_MUL_EN
  task automatic test_mul();
    logic [W+1:0] m;
    int n;
    for (int k = 0; k < 6; k++) begin
      A = (k == 0) ? 32'h0001_0000 : $urandom();
      B = (k == 0) ? 32'h0001_0001 : (k == 1 ? 32'hFFFF_FFFF : $urandom());
      if (k == 2) A = 32'h0;
      FS = 5'b01100;
      m = model(A, B, FS, '0);
      in_valid = 1'b1;
      cyc();
      A = $urandom();
      n = 1;
      while (!out_valid && n < 100) begin
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL mul_busy_%0d cycle %0d in_ready got %b exp 0", k, n, in_ready); end
        cyc();
        n++;
      end
      in_valid = 1'b0;
      tests++; if (n != W + 1) begin fails++; $display("FAIL mul_latency_%0d got %0d exp %0d", k, n, W + 1); end
      tests++;
      if ({F, C, V} !== m) begin
        fails++;
        $display("FAIL mul_result_%0d got F=%h C=%b V=%b exp %h", k, F, C, V, m);
      end
      cyc();
    end
  endtask
  task automatic test_mul_reset();
    int seen = 0;
    A = 32'h1234; B = 32'h5678; FS = 5'b01100;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (9) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tests++;
    if ({out_valid, in_ready, F} !== {2'b01, 32'd0}) begin
      fails++;
      $display("FAIL mul_reset_state got v=%b rdy=%b F=%h exp v=0 rdy=1 F=0", out_valid, in_ready, F);
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      cyc();
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL mul_reset_no_result got %0d valid cycles exp 0", seen); end
  endtask
`else
  task automatic test_mul();
    A = 32'hDEAD_BEEF; B = 32'h1234_5678; FS = 5'b01100;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, F, C, V, Z} !== {1'b1, 32'd0, 3'b001}) begin
      fails++;
      $display("FAIL undef_mul got v=%b F=%h C=%b V=%b Z=%b exp v=1 F=0 C=0 V=0 Z=1", out_valid, F, C, V, Z);
    end
    cyc();
  endtask
  task automatic test_mul_reset();
    A = 32'h5; FS = 5'b00001;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tests++;
    if ({out_valid, in_ready, F} !== {2'b01, 32'd0}) begin
      fails++;
      $display("FAIL reset_after_op got v=%b rdy=%b F=%h exp v=0 rdy=1 F=0", out_valid, in_ready, F);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_mul();
    test_mul_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
